// File: rtl/imem_server_if.sv
// Fetch channel between the processor fetch stage and the instruction-memory
// responder.
//   fetchReq  : request a fetch at pcIn
//   pcIn      : byte PC of the request
//   fetchRdy  : responder can accept a request this cycle
//   instWord  : returned instruction word, held between responses
//   instValid : one-cycle strobe qualifying instWord/fault
//   fault     : response is for a misaligned or out-of-range PC
// master = fetch stage, slave = memory responder.
interface imem_server_if #(
  parameter int unsigned DBITS = 32
);
  logic             fetchReq;
  logic [DBITS-1:0] pcIn;
  logic             fetchRdy;
  logic [DBITS-1:0] instWord;
  logic             instValid;
  logic             fault;

  modport master (
    output fetchReq, pcIn,
    input  fetchRdy, instWord, instValid, fault
  );

  modport slave (
    input  fetchReq, pcIn,
    output fetchRdy, instWord, instValid, fault
  );
endinterface

// File: rtl/imem_server.sv
// Instruction-memory responder: accepts a byte-PC fetch request, reads the
// on-chip instruction RAM and returns the word two cycles after the request.
// Misaligned or out-of-range PCs return a NOP (0) with fault set.
//   CLOCK_50   : clock, rising edge
//   RESET      : synchronous active-high reset (RAM contents are kept)
//   fetch      : fetch channel (slave side)
//   loadEn     : write loadData into the word addressed by loadAddr
//   loadAddr   : byte address of the write, low bits ignored
//   loadData   : word to write
//   fetchCount : responses issued since reset, wraps
module imem_server #(
  parameter int unsigned DBITS               = 32,
  parameter int unsigned IMEM_ADDR_BIT_WIDTH = 11,
  parameter int unsigned IMEM_PC_BITS_HI     = 13,
  parameter int unsigned IMEM_PC_BITS_LO     = 2,
  parameter int unsigned CNT_BITS            = 16
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  imem_server_if.slave        fetch,
  input  logic                loadEn,
  input  logic [DBITS-1:0]    loadAddr,
  input  logic [DBITS-1:0]    loadData,
  output logic [CNT_BITS-1:0] fetchCount
);

  localparam int unsigned WORDS = 1 << IMEM_ADDR_BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [DBITS-1:0] pc_q;
  logic [DBITS-1:0] mem [WORDS];

  logic [IMEM_ADDR_BIT_WIDTH-1:0] load_idx;
  logic [IMEM_ADDR_BIT_WIDTH-1:0] rd_idx;
  logic                           misaligned;
  logic                           out_of_range;
  logic                           pc_fault;
  logic                           unused_load_bits;

  assign load_idx     = loadAddr[IMEM_PC_BITS_HI-1:IMEM_PC_BITS_LO];
  assign rd_idx       = pc_q[IMEM_PC_BITS_HI-1:IMEM_PC_BITS_LO];
  assign misaligned   = (pc_q[IMEM_PC_BITS_LO-1:0] != '0);
  assign out_of_range = (pc_q[DBITS-1:IMEM_PC_BITS_HI] != '0);
  assign pc_fault     = misaligned | out_of_range;

  // Byte-offset and above-range address bits carry no meaning for a load.
  assign unused_load_bits = ^{loadAddr[DBITS-1:IMEM_PC_BITS_HI],
                              loadAddr[IMEM_PC_BITS_LO-1:0]};

  // Independent write port; never stalls and is unaffected by RESET.
  always_ff @(posedge CLOCK_50) begin
    if (loadEn) begin
      mem[load_idx] <= loadData;
    end
  end

  // Fetch FSM. The RAM read is registered straight into instWord on the
  // READ->RESP edge, so a same-cycle load to that word returns old data.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state           <= IDLE;
      pc_q            <= '0;
      fetch.fetchRdy  <= 1'b1;
      fetch.instWord  <= '0;
      fetch.instValid <= 1'b0;
      fetch.fault     <= 1'b0;
      fetchCount      <= '0;
    end else begin
      fetch.instValid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch.fetchReq) begin
            pc_q           <= fetch.pcIn;
            state          <= READ;
            fetch.fetchRdy <= 1'b0;
          end
        end
        READ: begin
          state           <= RESP;
          fetch.fetchRdy  <= 1'b1;
          fetch.instValid <= 1'b1;
          fetch.fault     <= pc_fault;
          fetch.instWord  <= pc_fault ? '0 : mem[rd_idx];
          fetchCount      <= fetchCount + CNT_BITS'(1);
        end
        RESP: begin
          if (fetch.fetchReq) begin
            pc_q           <= fetch.pcIn;
            state          <= READ;
            fetch.fetchRdy <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          fetch.fetchRdy <= 1'b1;
        end
      endcase
    end
  end

endmodule
